decode: RTL and testbench

//  Instruction decode stage, directly downstream of the fetch stage. Latches fetch's pc/ir into an
//  IF/ID register and holds the 32x32 register file, read with write-through bypass. Presents decoded

---
 rtl/decode.sv | 146 ++++++++++++++
 tb/tb_decode.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// decode: ID stage with IF/ID register, bypassed 32x32 register file and branch/jump redirect.
// Rev 1.0
`default_nettype none

module decode #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WORD_SIZE-1:0] pc_i,
  input  logic [WORD_SIZE-1:0] ir_i,
  output logic                 pc_load_o,
  output logic [WORD_SIZE-1:0] pc_data_o,
  input  logic                 stall_i,
  input  logic                 wb_en_i,
  input  logic [4:0]           wb_addr_i,
  input  logic [WORD_SIZE-1:0] wb_data_i,
  output logic                 valid_o,
  output logic [WORD_SIZE-1:0] pc_o,
  output logic [5:0]           opcode_o,
  output logic [5:0]           funct_o,
  output logic [4:0]           shamt_o,
  output logic [WORD_SIZE-1:0] rs_data_o,
  output logic [WORD_SIZE-1:0] rt_data_o,
  output logic [WORD_SIZE-1:0] imm_o,
  output logic [4:0]           dest_o
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] ir_q;
  logic                 valid_q;
  logic [WORD_SIZE-1:0] gpr [32];

  logic [4:0]           rs;
  logic [4:0]           rt;
  logic [4:0]           rd;
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 is_jr;
  logic [WORD_SIZE-1:0] imm_sext;
  logic [WORD_SIZE-1:0] imm_zext;
  logic [WORD_SIZE-1:0] rs_val;
  logic [WORD_SIZE-1:0] rt_val;

  // A valid instruction under stall holds; an empty stage may still fill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else if (!(stall_i && valid_q)) begin
      pc_q    <= pc_i;
      ir_q    <= ir_i;
      valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wb_en_i && (wb_addr_i != 5'd0)) begin
      gpr[wb_addr_i] <= wb_data_i;
    end
  end

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign is_jr    = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign imm_sext = {{(WORD_SIZE-16){ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {{(WORD_SIZE-16){1'b0}}, ir_q[15:0]};

  // Write-through: a same-cycle writeback is visible to the read.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0) begin
      rs_val = (wb_en_i && (wb_addr_i == rs)) ? wb_data_i : gpr[rs];
    end
    if (rt != 5'd0) begin
      rt_val = (wb_en_i && (wb_addr_i == rt)) ? wb_data_i : gpr[rt];
    end
  end

  always_comb begin
    imm_o = imm_sext;
    if ((opcode >= OP_ANDI) && (opcode <= OP_XORI)) begin
      imm_o = imm_zext;
    end else if (opcode == OP_JAL) begin
      imm_o = pc_q + WORD_SIZE'(2);
    end
  end

  always_comb begin
    dest_o = rt;
    case (opcode)
      OP_RTYPE:                   dest_o = is_jr ? 5'd0 : rd;
      OP_JAL:                     dest_o = 5'd31;
      OP_BEQ, OP_BNE, OP_J, OP_SW: dest_o = 5'd0;
      default:                    dest_o = rt;
    endcase
  end

  // Stall hold wins over any redirect; the branch fires once it is released.
  always_comb begin
    pc_load_o = 1'b0;
    pc_data_o = pc_i;
    if (valid_q && stall_i) begin
      pc_load_o = 1'b1;
      pc_data_o = pc_i;
    end else if (valid_q) begin
      if (((opcode == OP_BEQ) && (rs_val == rt_val)) ||
          ((opcode == OP_BNE) && (rs_val != rt_val))) begin
        pc_load_o = 1'b1;
        pc_data_o = pc_q + imm_sext + WORD_SIZE'(1);
      end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
        pc_load_o = 1'b1;
        pc_data_o = {pc_q[WORD_SIZE-1:26], ir_q[25:0]};
      end else if (is_jr) begin
        pc_load_o = 1'b1;
        pc_data_o = rs_val;
      end
    end
  end

  assign valid_o   = valid_q;
  assign pc_o      = pc_q;
  assign opcode_o  = opcode;
  assign funct_o   = funct;
  assign shamt_o   = ir_q[10:6];
  assign rs_data_o = rs_val;
  assign rt_data_o = rt_val;

endmodule

`default_nettype wire

// File: tb/tb_decode.sv
// tb_decode: directed self-checking bench for the decode stage.
// Rev 1.0
`default_nettype none

module tb_decode;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic [31:0] ir_i;
  logic        pc_load_o;
  logic [31:0] pc_data_o;
  logic        stall_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [5:0]  opcode_o;
  logic [5:0]  funct_o;
  logic [4:0]  shamt_o;
  logic [31:0] rs_data_o;
  logic [31:0] rt_data_o;
  logic [31:0] imm_o;
  logic [4:0]  dest_o;

  int checks = 0;
  int errors = 0;

  decode #(.WORD_SIZE(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .ir_i(ir_i),
    .pc_load_o(pc_load_o), .pc_data_o(pc_data_o), .stall_i(stall_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .valid_o(valid_o), .pc_o(pc_o), .opcode_o(opcode_o), .funct_o(funct_o),
    .shamt_o(shamt_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
    .imm_o(imm_o), .dest_o(dest_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ienc(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] renc(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] jenc(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic cycle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] ir);
    pc_i = pc;
    ir_i = ir;
  endtask

  task automatic gpr_write(input logic [4:0] addr, input logic [31:0] data);
    wb_en_i = 1'b1; wb_addr_i = addr; wb_data_i = data;
    cycle();
    wb_en_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'h0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; stall_i = 1'b0; wb_en_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'h0;
    present(32'h55, 32'h0);
    cycle(); cycle(); #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (pc_load_o !== 1'b0) begin errors++; $display("FAIL reset_pc_load: got %b expected 0", pc_load_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc_o); end
    present(32'h0, 32'h0);
    rst_i = 1'b0;
    cycle(); #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", valid_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL first_pc: got %h expected 0", pc_o); end
  endtask

  task automatic test_regfile();
    gpr_write(5'd5, 32'd7);
    gpr_write(5'd0, 32'hFFFF);
    present(32'h1, renc(5'd5, 5'd0, 5'd6, 5'd4, 6'h21));
    cycle(); #1;
    checks++; if (rs_data_o !== 32'd7) begin errors++; $display("FAIL read_r5: got %h expected 7", rs_data_o); end
    checks++; if (rt_data_o !== 32'd0) begin errors++; $display("FAIL read_r0: got %h expected 0", rt_data_o); end
    checks++; if (dest_o !== 5'd6) begin errors++; $display("FAIL rtype_dest: got %0d expected 6", dest_o); end
    checks++; if (funct_o !== 6'h21 || shamt_o !== 5'd4 || opcode_o !== 6'h00) begin errors++;
      $display("FAIL rtype_fields: got op %h fn %h sh %0d expected 00 21 4", opcode_o, funct_o, shamt_o); end
    wb_en_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFF; #1;
    checks++; if (rt_data_o !== 32'd0) begin errors++; $display("FAIL bypass_r0: got %h expected 0", rt_data_o); end
    wb_addr_i = 5'd5; wb_data_i = 32'd9; #1;
    checks++; if (rs_data_o !== 32'd9) begin errors++; $display("FAIL bypass_rs: got %h expected 9", rs_data_o); end
    cycle();
    wb_en_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'h0;
  endtask

  task automatic test_branch();
    gpr_write(5'd1, 32'd4);
    gpr_write(5'd2, 32'd4);
    present(32'h10, ienc(6'h04, 5'd1, 5'd2, 16'd3));
    cycle();
    present(32'h11, 32'h0); #1;
    checks++; if (pc_o !== 32'h10) begin errors++; $display("FAIL beq_pc: got %h expected 10", pc_o); end
    checks++; if (pc_load_o !== 1'b1 || pc_data_o !== 32'h14) begin errors++;
      $display("FAIL beq_taken: got load %b data %h expected 1 14", pc_load_o, pc_data_o); end
    checks++; if (dest_o !== 5'd0) begin errors++; $display("FAIL beq_dest: got %0d expected 0", dest_o); end
    cycle();
    present(32'h14, ienc(6'h05, 5'd1, 5'd2, 16'hFFFF)); #1;
    checks++; if (pc_o !== 32'h11 || pc_load_o !== 1'b0) begin errors++;
      $display("FAIL delay_slot: got pc %h load %b expected 11 0", pc_o, pc_load_o); end
    cycle();
    present(32'h15, ienc(6'h05, 5'd1, 5'd5, 16'hFFFE)); #1;
    checks++; if (pc_o !== 32'h14 || pc_load_o !== 1'b0) begin errors++;
      $display("FAIL bne_not_taken: got pc %h load %b expected 14 0", pc_o, pc_load_o); end
    cycle();
    present(32'h16, 32'h0); #1;
    checks++; if (pc_load_o !== 1'b1 || pc_data_o !== 32'h14) begin errors++;
      $display("FAIL bne_taken: got load %b data %h expected 1 14", pc_load_o, pc_data_o); end
    checks++; if (imm_o !== 32'hFFFFFFFE) begin errors++; $display("FAIL bne_imm_sext: got %h expected fffffffe", imm_o); end
    cycle();
  endtask

  task automatic test_stall();
    present(32'h20, ienc(6'h09, 5'd1, 5'd8, 16'd5));
    cycle();
    present(32'h21, ienc(6'h0D, 5'd0, 5'd3, 16'h1));
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pc_o !== 32'h20 || dest_o !== 5'd8 || pc_load_o !== 1'b1 || pc_data_o !== 32'h21) begin errors++;
        $display("FAIL stall_hold[%0d]: got pc %h dest %0d load %b data %h expected 20 8 1 21", i, pc_o, dest_o, pc_load_o, pc_data_o); end
      cycle();
    end
    stall_i = 1'b0; #1;
    checks++; if (pc_o !== 32'h20 || pc_load_o !== 1'b0) begin errors++;
      $display("FAIL stall_release: got pc %h load %b expected 20 0", pc_o, pc_load_o); end
    cycle();
    present(32'h22, 32'h0); #1;
    checks++; if (pc_o !== 32'h21) begin errors++; $display("FAIL after_stall_pc: got %h expected 21", pc_o); end
    cycle(); #1;
    checks++; if (pc_o !== 32'h22) begin errors++; $display("FAIL after_stall_next: got %h expected 22", pc_o); end
  endtask

  task automatic test_jr_stall();
    gpr_write(5'd31, 32'h40);
    present(32'h50, renc(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
    cycle();
    present(32'h51, 32'h0);
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (pc_load_o !== 1'b1 || pc_data_o !== 32'h51) begin errors++;
        $display("FAIL jr_stalled[%0d]: got load %b data %h expected 1 51", i, pc_load_o, pc_data_o); end
      cycle();
    end
    stall_i = 1'b0; #1;
    checks++; if (pc_load_o !== 1'b1 || pc_data_o !== 32'h40 || dest_o !== 5'd0) begin errors++;
      $display("FAIL jr_release: got load %b data %h dest %0d expected 1 40 0", pc_load_o, pc_data_o, dest_o); end
    cycle();
    present(32'h40, 32'h0); #1;
    checks++; if (pc_o !== 32'h51 || pc_load_o !== 1'b0) begin errors++;
      $display("FAIL jr_once: got pc %h load %b expected 51 0", pc_o, pc_load_o); end
    cycle();
  endtask

  task automatic test_jal_imm();
    present(32'h30, jenc(6'h03, 26'h100));
    cycle(); #1;
    checks++; if (dest_o !== 5'd31 || imm_o !== 32'h32) begin errors++;
      $display("FAIL jal_link: got dest %0d imm %h expected 31 32", dest_o, imm_o); end
    checks++; if (pc_load_o !== 1'b1 || pc_data_o !== 32'h100) begin errors++;
      $display("FAIL jal_target: got load %b data %h expected 1 100", pc_load_o, pc_data_o); end
    present(32'h31, ienc(6'h0D, 5'd0, 5'd3, 16'h8000));
    cycle(); #1;
    checks++; if (imm_o !== 32'h00008000 || dest_o !== 5'd3) begin errors++;
      $display("FAIL ori_zext: got imm %h dest %0d expected 00008000 3", imm_o, dest_o); end
    present(32'h32, ienc(6'h23, 5'd1, 5'd4, 16'h8000));
    cycle(); #1;
    checks++; if (imm_o !== 32'hFFFF8000 || dest_o !== 5'd4) begin errors++;
      $display("FAIL lw_sext: got imm %h dest %0d expected ffff8000 4", imm_o, dest_o); end
    present(32'h33, ienc(6'h2B, 5'd1, 5'd4, 16'h0004));
    cycle(); #1;
    checks++; if (dest_o !== 5'd0) begin errors++; $display("FAIL sw_dest: got %0d expected 0", dest_o); end
    present(32'hFC000005, jenc(6'h02, 26'h10));
    cycle(); #1;
    checks++; if (pc_load_o !== 1'b1 || pc_data_o !== 32'hFC000010 || dest_o !== 5'd0) begin errors++;
      $display("FAIL j_upper: got load %b data %h dest %0d expected 1 fc000010 0", pc_load_o, pc_data_o, dest_o); end
  endtask

  task automatic test_reset_mid_stall();
    present(32'h60, 32'h0);
    cycle();
    present(32'h61, 32'h0);
    stall_i = 1'b1;
    cycle();
    rst_i = 1'b1;
    cycle(); #1;
    checks++; if (valid_o !== 1'b0 || pc_load_o !== 1'b0) begin errors++;
      $display("FAIL reset_mid_stall: got valid %b load %b expected 0 0", valid_o, pc_load_o); end
    rst_i = 1'b0;
    stall_i = 1'b0;
    cycle(); #1;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h61) begin errors++;
      $display("FAIL reset_recover: got valid %b pc %h expected 1 61", valid_o, pc_o); end
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_branch();
    test_stall();
    test_jr_stall();
    test_jal_imm();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
